// File: rtl/aes_ctr_pkg.sv
// Shared types and widths for the AES-192 CTR sequencer.
package aes_ctr_pkg;

    localparam int unsigned AES_BLK_W    = 128;
    localparam int unsigned AES192_KEY_W = 192;
    localparam int unsigned BLK_CNT_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/aes_ctr_inc.sv
// Increments the low CTR_W bits of a 128-bit counter block modulo 2^CTR_W;
// the nonce bits above CTR_W pass through untouched.
module aes_ctr_inc
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_W = 32
) (
    input  logic [AES_BLK_W-1:0] blk_in,
    output logic [AES_BLK_W-1:0] blk_out
);

    localparam logic [AES_BLK_W-1:0] CTR_MASK =
        (CTR_W >= AES_BLK_W) ? '1 : ((AES_BLK_W'(1) << CTR_W) - AES_BLK_W'(1));

    // Carry out of the counter field is discarded by the mask.
    always_comb begin
        blk_out = (blk_in & ~CTR_MASK) | ((blk_in + AES_BLK_W'(1)) & CTR_MASK);
    end

endmodule

// File: rtl/aes_ctr_seq.sv
// Upstream sequencer for the aes_192_sed CTR core: feeds counter/data/key, waits
// for the core result and streams it out. `AES_CTR_SEQ_TIMEOUT_EN adds a WAIT watchdog.
module aes_ctr_seq
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_load,
    input  logic [AES192_KEY_W-1:0] cfg_key,
    input  logic [AES_BLK_W-1:0]    cfg_iv,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AES_BLK_W-1:0]    in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AES_BLK_W-1:0]    out_data,
    output logic                    out_last,
    output logic                    core_start,
    output logic [AES_BLK_W-1:0]    core_state,
    output logic [AES_BLK_W-1:0]    core_p_c_text,
    output logic [AES192_KEY_W-1:0] core_key,
    input  logic [AES_BLK_W-1:0]    core_out,
    input  logic                    core_out_valid,
    output logic                    busy,
    output logic [BLK_CNT_W-1:0]    blk_cnt,
    output logic                    err
);

    state_t state, state_nxt;

    logic [AES192_KEY_W-1:0] key_q;
    logic [AES_BLK_W-1:0]    ctr_q;
    logic [AES_BLK_W-1:0]    iv_q;
    logic [AES_BLK_W-1:0]    data_q;
    logic [AES_BLK_W-1:0]    ctr_inc;
    logic                    last_q;
    logic                    armed;
    logic                    done;
    logic                    timeout;

    aes_ctr_inc #(.CTR_W(CTR_W)) u_inc (
        .blk_in  (ctr_q),
        .blk_out (ctr_inc)
    );

    // A stale out_valid from the previous block is ignored until the core drops it.
    assign done = (state == WAIT) && core_out_valid && armed;

`ifdef AES_CTR_SEQ_TIMEOUT_EN
    logic [31:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == START) begin
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign timeout = (state == WAIT) && !done && (wd_cnt == 32'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!cfg_load && in_valid) state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (done)         state_nxt = OUT;
                else if (timeout) state_nxt = IDLE;
            end
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state == IDLE) && !cfg_load;
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q      <= '0;
            ctr_q      <= '0;
            iv_q       <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            armed      <= 1'b0;
            core_start <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            blk_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            if (cfg_load && (state != IDLE)) err <= 1'b1;
            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        key_q   <= cfg_key;
                        ctr_q   <= cfg_iv;
                        iv_q    <= cfg_iv;
                        blk_cnt <= '0;
                        err     <= 1'b0;
                    end else if (in_valid) begin
                        data_q <= in_data;
                        last_q <= in_last;
                    end
                end
                LOAD:  core_start <= 1'b1;
                START: armed      <= 1'b0;
                WAIT: begin
                    if (!core_out_valid) armed <= 1'b1;
                    if (done) begin
                        out_data <= core_out;
                        out_last <= last_q;
                        ctr_q    <= ctr_inc;
                        blk_cnt  <= blk_cnt + BLK_CNT_W'(1);
                    end else if (timeout) begin
                        err        <= 1'b1;
                        core_start <= 1'b0;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        core_start <= 1'b0;
                        if (last_q) ctr_q <= iv_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_state    = ctr_q;
    assign core_p_c_text = data_q;
    assign core_key      = key_q;

endmodule
